// File: rtl/axil_master_cmd.sv
// axil_master_cmd: single-outstanding AXI-Lite master driven by a simple
// valid/ready command stream. Each command becomes exactly one AXI-Lite write
// (AW + W, then B) or read (AR, then R). One response word is returned per
// command on a valid/ready response stream.
module axil_master_cmd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,

  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,

  // AXI-Lite write address channel
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,

  // AXI-Lite write data channel
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,

  // AXI-Lite write response channel
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,

  // AXI-Lite read address channel
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,

  // AXI-Lite read data channel
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                state_reg, state_next;

  // latched command payload, held stable for the whole transaction
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [STRB_WIDTH-1:0] wstrb_reg, wstrb_next;

  // registered AXI handshake outputs
  logic                  awvalid_reg, awvalid_next;
  logic                  wvalid_reg, wvalid_next;
  logic                  bready_reg, bready_next;
  logic                  arvalid_reg, arvalid_next;
  logic                  rready_reg, rready_next;

  // registered response word
  logic                  rsp_valid_reg, rsp_valid_next;
  logic                  rsp_write_reg, rsp_write_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]            rsp_resp_reg, rsp_resp_next;

  // handshake qualifiers
  logic                  cmd_fire;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  b_fire;
  logic                  ar_fire;
  logic                  r_fire;
  logic                  rsp_fire;

  // Only IDLE accepts a command; reset blocks acceptance combinationally so a
  // command offered during reset is never taken.
  assign cmd_ready = (state_reg == IDLE) && !rst;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign aw_fire  = awvalid_reg && m_axil_awready;
  assign w_fire   = wvalid_reg && m_axil_wready;
  assign b_fire   = bready_reg && m_axil_bvalid;
  assign ar_fire  = arvalid_reg && m_axil_arready;
  assign r_fire   = rready_reg && m_axil_rvalid;
  assign rsp_fire = rsp_valid_reg && rsp_ready;

  // Output drive: payloads come straight from the latched command
  assign m_axil_awaddr  = addr_reg;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_reg;
  assign m_axil_wdata   = wdata_reg;
  assign m_axil_wstrb   = wstrb_reg;
  assign m_axil_wvalid  = wvalid_reg;
  assign m_axil_bready  = bready_reg;
  assign m_axil_araddr  = addr_reg;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_reg;
  assign m_axil_rready  = rready_reg;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_write = rsp_write_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_resp  = rsp_resp_reg;

  // Next-state and next-output logic for the transaction sequencer
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_write_next = rsp_write_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          wstrb_next = cmd_wstrb;
          if (cmd_write) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = WR;
          end else begin
            arvalid_next = 1'b1;
            state_next   = RD_ADDR;
          end
        end
      end

      WR: begin
        // AW and W retire independently; move on once neither is pending
        if (aw_fire) begin
          awvalid_next = 1'b0;
        end
        if (w_fire) begin
          wvalid_next = 1'b0;
        end
        if (!awvalid_next && !wvalid_next) begin
          bready_next = 1'b1;
          state_next  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (b_fire) begin
          bready_next    = 1'b0;
          rsp_write_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_resp_next  = m_axil_bresp;
          rsp_valid_next = 1'b1;
          state_next     = RSP;
        end
      end

      RD_ADDR: begin
        if (ar_fire) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (r_fire) begin
          rready_next    = 1'b0;
          rsp_write_next = 1'b0;
          rsp_rdata_next = m_axil_rdata;
          rsp_resp_next  = m_axil_rresp;
          rsp_valid_next = 1'b1;
          state_next     = RSP;
        end
      end

      RSP: begin
        if (rsp_fire) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        awvalid_next   = 1'b0;
        wvalid_next    = 1'b0;
        bready_next    = 1'b0;
        arvalid_next   = 1'b0;
        rready_next    = 1'b0;
        rsp_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= 2'b00;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_write_reg <= rsp_write_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
    end
  end

endmodule

// File: tb/tb_axil_master_cmd.sv
// Bench for axil_master_cmd: a behavioural AXI-Lite memory slave with
// selectable ready behaviour, a plain-array reference memory, directed
// scenarios and a randomized command run.
module tb_axil_master_cmd;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]    m_axil_awprot, m_axil_arprot;
  logic          m_axil_awvalid, m_axil_awready;
  logic [DW-1:0] m_axil_wdata, m_axil_rdata;
  logic [SW-1:0] m_axil_wstrb;
  logic          m_axil_wvalid, m_axil_wready;
  logic [1:0]    m_axil_bresp, m_axil_rresp;
  logic          m_axil_bvalid, m_axil_bready;
  logic          m_axil_arvalid, m_axil_arready;
  logic          m_axil_rvalid, m_axil_rready;

  always #5 clk = ~clk;

  axil_master_cmd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  // ---------------- behavioural slave ----------------
  // mode 0: always ready, mode 1: random readiness, mode 2: bench-forced
  int            mode = 0;
  logic          force_awready = 0, force_wready = 0, force_arready = 0;
  logic          force_resp = 0;
  logic          rnd_aw = 0, rnd_w = 0, rnd_ar = 0;
  logic [DW-1:0] smem [32];
  logic          aw_got, w_got, ar_got;
  logic [AW-1:0] aw_a, ar_a;
  logic [DW-1:0] w_d;
  logic [SW-1:0] w_s;
  int            aw_cnt = 0, w_cnt = 0, ar_cnt = 0, proto_err = 0;
  logic          aw_pend = 0, w_pend = 0, ar_pend = 0;
  logic [AW-1:0] aw_snap, ar_snap;
  logic [DW-1:0] w_snap;

  assign m_axil_awready = (mode == 2) ? force_awready : rnd_aw;
  assign m_axil_wready  = (mode == 2) ? force_wready  : rnd_w;
  assign m_axil_arready = (mode == 2) ? force_arready : rnd_ar;

  // Address 31 is the slave's error region: accesses there answer SLVERR.
  function automatic logic [1:0] slave_resp(input logic [AW-1:0] a);
    return (a == 5'd31) ? 2'b10 : 2'b00;
  endfunction

  always @(posedge clk) begin
    bit go_b, go_r;
    go_b = (mode == 2) ? force_resp : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    go_r = (mode == 2) ? force_resp : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    // a valid not yet accepted must persist with an unchanged payload
    if (!rst && aw_pend && (m_axil_awvalid !== 1'b1 || m_axil_awaddr !== aw_snap)) proto_err <= proto_err + 1;
    if (!rst && w_pend && (m_axil_wvalid !== 1'b1 || m_axil_wdata !== w_snap)) proto_err <= proto_err + 1;
    if (!rst && ar_pend && (m_axil_arvalid !== 1'b1 || m_axil_araddr !== ar_snap)) proto_err <= proto_err + 1;
    aw_pend <= !rst && m_axil_awvalid && !m_axil_awready;
    w_pend  <= !rst && m_axil_wvalid && !m_axil_wready;
    ar_pend <= !rst && m_axil_arvalid && !m_axil_arready;
    aw_snap <= m_axil_awaddr;
    w_snap  <= m_axil_wdata;
    ar_snap <= m_axil_araddr;
    rnd_aw <= (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    rnd_w  <= (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    rnd_ar <= (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst) begin
      aw_got <= 0; w_got <= 0; ar_got <= 0;
      m_axil_bvalid <= 0; m_axil_rvalid <= 0;
      m_axil_bresp <= 0; m_axil_rresp <= 0; m_axil_rdata <= 0;
    end else begin
      if (m_axil_awvalid && m_axil_awready) begin
        aw_got <= 1; aw_a <= m_axil_awaddr; aw_cnt <= aw_cnt + 1;
      end
      if (m_axil_wvalid && m_axil_wready) begin
        w_got <= 1; w_d <= m_axil_wdata; w_s <= m_axil_wstrb; w_cnt <= w_cnt + 1;
      end
      if (m_axil_arvalid && m_axil_arready) begin
        ar_got <= 1; ar_a <= m_axil_araddr; ar_cnt <= ar_cnt + 1;
      end
      if (aw_got && w_got && !m_axil_bvalid && go_b) begin
        for (int b = 0; b < SW; b++)
          if (w_s[b]) smem[aw_a][8*b +: 8] <= w_d[8*b +: 8];
        m_axil_bvalid <= 1; m_axil_bresp <= slave_resp(aw_a);
        aw_got <= 0; w_got <= 0;
      end
      if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 0;
      if (ar_got && !m_axil_rvalid && go_r) begin
        m_axil_rvalid <= 1; m_axil_rdata <= smem[ar_a]; m_axil_rresp <= slave_resp(ar_a);
        ar_got <= 0;
      end
      if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 0;
    end
  end

  // ---------------- reference model and checks ----------------
  logic [DW-1:0] ref_mem [32];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer a command (caller is mid-cycle) and return just after its accept edge.
  task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input bit keep);
    int n = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 300) begin
      @(negedge clk); n++;
    end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) cmd_valid = 0;
  endtask

  // Wait for the response, optionally stall it, then check and consume it.
  task automatic collect_rsp(input logic ew, input logic [DW-1:0] ed, input logic [1:0] er,
                             input int hold);
    int n = 0;
    logic [DW-1:0] snap;
    @(negedge clk);
    while (!rsp_valid && n < 300) begin
      @(negedge clk); n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
    snap = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_rdata", rsp_rdata, snap);
      chk("stall_cmd_ready", cmd_ready, 0);
    end
    chk("rsp_write", rsp_write, ew);
    chk("rsp_rdata", rsp_rdata, ed);
    chk("rsp_resp", rsp_resp, er);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    @(negedge clk);
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
  endtask

  // One full command against the reference memory.
  task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input int hold, input bit keep);
    logic [DW-1:0] ed;
    if (w) begin
      for (int b = 0; b < SW; b++)
        if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      ed = '0;
    end else begin
      ed = ref_mem[a];
    end
    issue_cmd(w, a, d, s, keep);
    collect_rsp(w, ed, (a == 5'd31) ? 2'b10 : 2'b00, hold);
    $display("txn %s addr=%0d data=%h resp=%0d", w ? "WR" : "RD", a, rsp_rdata, rsp_resp);
  endtask

  initial begin
    int aw0, ar0;
    for (int i = 0; i < 32; i++) begin
      smem[i] = '0; ref_mem[i] = '0;
    end
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awvalid", m_axil_awvalid, 0);
    chk("rst_wvalid", m_axil_wvalid, 0);
    chk("rst_arvalid", m_axil_arvalid, 0);
    chk("rst_bready", m_axil_bready, 0);
    chk("rst_rready", m_axil_rready, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_rsp_write", rsp_write, 0);
    chk("prot", {m_axil_awprot, m_axil_arprot}, 0);
    rst = 0;
    #1 chk("post_rst_cmd_ready", cmd_ready, 1);

    // write/read and partial strobe, with a 5-cycle response stall
    mode = 0;
    run_cmd(1, 1, 2345, 4'hF, 0, 0);
    run_cmd(0, 1, 0, 0, 0, 0);
    run_cmd(1, 2, 32'hFFFF_FFFF, 4'hF, 0, 0);
    run_cmd(1, 2, 32'h0, 4'b0011, 0, 0);
    run_cmd(0, 2, 0, 0, 5, 0);
    chk("partial_strobe_value", rsp_rdata, 32'hFFFF_0000);

    // split AW/W handshakes with an error response
    mode = 2;
    issue_cmd(1, 31, 32'hA5A5_0F0F, 4'hF, 0);
    ref_mem[31] = 32'hA5A5_0F0F;
    @(negedge clk);
    chk("split_awvalid0", m_axil_awvalid, 1);
    chk("split_wvalid0", m_axil_wvalid, 1);
    force_awready = 1;
    @(negedge clk);
    force_awready = 0;
    chk("split_awvalid1", m_axil_awvalid, 0);
    chk("split_wvalid1", m_axil_wvalid, 1);
    chk("split_bready1", m_axil_bready, 0);
    repeat (2) begin
      @(negedge clk);
      chk("split_wvalid_hold", m_axil_wvalid, 1);
      chk("split_bready_hold", m_axil_bready, 0);
    end
    force_wready = 1;
    @(negedge clk);
    force_wready = 0;
    chk("split_wvalid_drop", m_axil_wvalid, 0);
    chk("split_bready_rise", m_axil_bready, 1);
    force_resp = 1;
    collect_rsp(1, 0, 2'b10, 0);
    force_resp = 0;

    // reset while waiting for read data
    issue_cmd(0, 1, 0, 0, 0);
    @(negedge clk);
    chk("rr_arvalid", m_axil_arvalid, 1);
    force_arready = 1;
    @(negedge clk);
    force_arready = 0;
    chk("rr_rready", m_axil_rready, 1);
    rst = 1;
    @(negedge clk);
    chk("rr_arvalid_rst", m_axil_arvalid, 0);
    chk("rr_rready_rst", m_axil_rready, 0);
    chk("rr_rsp_valid_rst", rsp_valid, 0);
    chk("rr_cmd_ready_rst", cmd_ready, 0);
    rst = 0;
    #1 chk("rr_cmd_ready_after", cmd_ready, 1);
    mode = 0;
    run_cmd(0, 1, 0, 0, 0, 0);
    chk("rr_readback", rsp_rdata, 2345);

    // back-to-back write/read pairs with cmd_valid held high
    aw0 = aw_cnt; ar0 = ar_cnt;
    for (int i = 0; i < 8; i++) begin
      run_cmd(1, AW'(i), $urandom, 4'hF, 0, 1);
      run_cmd(0, AW'(i), 0, 0, 0, 1);
    end
    cmd_valid = 0;
    chk("b2b_aw_count", aw_cnt - aw0, 8);
    chk("b2b_ar_count", ar_cnt - ar0, 8);

    // randomized commands with random slave readiness
    mode = 1;
    for (int i = 0; i < 80; i++) begin
      run_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
              SW'($urandom_range(0, 15)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    chk("aw_w_count_match", aw_cnt, w_cnt);
    chk("protocol_errors", proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_master_cmd.md
Name: axil_master_cmd

Overview:
- Single-outstanding AXI-Lite master that turns a simple valid/ready command stream into AXI-Lite write or read transactions.
- Sits directly upstream of axil_ram and drives its s_axil_* slave port. It replaces hand-sequenced bench/control logic.
- Returns one response word (read data plus resp code) per command on a valid/ready response stream.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (multiple of 8)
- ADDR_WIDTH, 5, address width in bits
- STRB_WIDTH, DATA_WIDTH/8, write strobe width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  STRB_WIDTH  write strobes (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  bresp or rresp
- m_axil_awaddr/awprot/awvalid out, awready in  ADDR_WIDTH/3/1/1
- m_axil_wdata/wstrb/wvalid out, wready in  DATA_WIDTH/STRB_WIDTH/1/1
- m_axil_bresp in 2, bvalid in 1, bready out 1
- m_axil_araddr/arprot/arvalid out, arready in  ADDR_WIDTH/3/1/1
- m_axil_rdata in DATA_WIDTH, rresp in 2, rvalid in 1, rready out 1

Behaviour:
- Reset values (rst=1 at a clock edge): state=IDLE; awvalid, wvalid, bready, arvalid, rready, rsp_valid = 0; rsp_rdata=0; rsp_resp=0; rsp_write=0. cmd_ready=0 while rst is high.
- awprot and arprot are constant 3'b000.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1, and only in IDLE.
  - On accept, latch addr, wdata, wstrb, write.
  - Next cycle: if write, enter WR with awvalid=1 and wvalid=1; if read, enter RD_ADDR with arvalid=1.
- WR:
  - AW and W complete independently. awvalid drops the cycle after awvalid&awready; wvalid drops the cycle after wvalid&wready.
  - Payloads stay stable while valid is asserted.
  - When both have completed (same cycle or different cycles), enter WR_RESP with bready=1.
- WR_RESP: on bvalid&bready, capture bresp into rsp_resp, set rsp_rdata=0 and bready=0, then enter RSP.
- RD_ADDR: on arvalid&arready, set arvalid=0 and rready=1, then enter RD_DATA.
- RD_DATA: on rvalid&rready, capture rdata and rresp, set rready=0, then enter RSP.
- RSP:
  - rsp_valid=1; rsp_* held stable until rsp_valid&rsp_ready, then rsp_valid=0 and return to IDLE.
  - The next command can be accepted the cycle after the response handshake.
- Minimum latency (slave ready at every step): command accept to rsp_valid = 3 cycles for a write, 3 for a read. Against axil_ram, add that slave's internal registered latency.
- No outstanding transaction limit other than one: no command is accepted from accept until the response handshake.
- A bvalid or rvalid arriving before its ready is asserted is held by the slave per AXI; the block never drops it.
- rst asserted mid-transaction: the block returns to IDLE immediately, all valids/readies go 0, and the pending command and response are discarded. Resetting the attached slave too is the system's responsibility.
- Non-zero bresp/rresp is passed through unchanged; no retry.

Test Plan:
- Write then read against axil_ram (DATA_WIDTH=32, ADDR_WIDTH=5):
  - cmd write addr=1 wdata=2345 wstrb=4'hF -> rsp_valid, rsp_write=1, rsp_resp=0.
  - cmd read addr=1 -> rsp_rdata=2345, rsp_resp=0.
- Partial strobe:
  - write addr=2 data=32'hFFFFFFFF, then write addr=2 data=0 wstrb=4'b0011.
  - read addr=2 -> rsp_rdata=32'hFFFF0000.
- Split AW/W with a stub slave:
  - awready at cycle 1, wready at cycle 4 -> awvalid low from cycle 2, wvalid high until cycle 4 handshake, bready rises only after both.
  - bresp=2'b10 -> rsp_resp=2.
- Response backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
- Reset mid-read:
  - assert rst while in RD_DATA -> next cycle arvalid=rready=rsp_valid=0, cmd_ready=0 during rst, cmd_ready=1 first cycle after rst deasserts.
  - a subsequent read addr=1 returns correct data.
- Back-to-back: 8 alternating write/read commands to addresses 0..7 with cmd_valid held high -> exactly one AXI transaction per command, in order, each readback equals the value written.
